hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage MIPS core. Drives PC enable, the IF/ID and ID/EX
//  load-enable/flush pins, and the halt line. Detects load-use hazards, flushes on EX-stage
//  redirects (taken branch, jump, jr, jal), and drains then freezes the pipe on exit syscall.
//  Sits beside the stage registers; all pipeline-register control originates here.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard (1..7; >1 for slow data memory)
//  DRAIN_CYCLES       2   cycles to let MEM/WB retire before HALT (1..7)
//  HALT_CODE          10  $v0 value that makes syscall halt the core
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  id_rs        in   5   rs of instruction in ID
//  id_rt        in   5   rt of instruction in ID
//  id_use_rs    in   1   ID instruction reads rs
//  id_use_rt    in   1   ID instruction reads rt
//  ex_ld        in   1   instruction in EX is a load
//  ex_wreg      in   5   destination register of EX instruction
//  ex_redirect  in   1   EX resolved taken branch / Jmp / Jr / Jal (PC takes target this edge)
//  ex_syscall   in   1   Syscall in EX
//  ex_v0        in   32  forwarded $v0 value in EX
//  resume       in   1   single-cycle pulse: leave HALT
//  pc_en        out  1   PC load enable
//  if_id_en     out  1   IF/ID load enable
//  if_id_zero   out  1   IF/ID synchronous clear (bubble)
//  id_ex_stall  out  1   ID/EX load enable (1 = load); wired to ID/EX stall pin
//  id_ex_zero   out  1   ID/EX synchronous clear (bubble); overrides load
//  halt         out  1   core halted
//  stall_cnt    out  32  load-use bubble count (HAZARD_STATS_EN only, else 0)
//  flush_cnt    out  32  redirect flush count (HAZARD_STATS_EN only, else 0)
// BEHAVIOUR
//  - States: RUN, LDSTALL, DRAIN, HALT. Registered: state, 3-bit cnt, counters.
//    Outputs combinational from state + current inputs (act in detection cycle).
//  - Reset (async, rst_n=0): state=RUN, cnt=0, counters=0. Outputs while in reset:
//    pc_en=0, if_id_en=0, id_ex_stall=0, if_id_zero=1, id_ex_zero=1, halt=0.
//  - Hazard terms: ldu = ex_ld & ex_wreg!=0 & ((id_use_rs & id_rs==ex_wreg) |
//    (id_use_rt & id_rt==ex_wreg)); hlt = ex_syscall & ex_v0==HALT_CODE.
//  - RUN priority hlt > ex_redirect > ldu > none:
//    hlt: pc_en=0, if_id_en=0, id_ex_zero=1; next DRAIN, cnt=DRAIN_CYCLES-1.
//    redirect: pc_en=1, if_id_zero=1, id_ex_zero=1 (2 bubbles); stay RUN; flush_cnt+1.
//    ldu: pc_en=0, if_id_en=0, id_ex_zero=1; stall_cnt+1;
//      LOAD_STALL_CYCLES=1 -> stay RUN; else -> LDSTALL, cnt=LOAD_STALL_CYCLES-2.
//    none: pc_en=1, if_id_en=1, id_ex_stall=1, zeros=0.
//  - LDSTALL: same outputs as ldu; stall_cnt+1 per cycle; cnt==0 -> RUN else cnt-1.
//    ex_redirect/hlt ignored (EX holds a bubble by construction).
//  - DRAIN: pc_en=0, if_id_en=0, id_ex_zero=1; cnt==0 -> HALT else cnt-1.
//  - HALT: all enables 0, zeros 0, halt=1; resume=1 -> RUN (next cycle normal).
//    resume outside HALT ignored.
//  - Enable and zero of one stage never both asserted except id_ex_zero with
//    id_ex_stall=0. Counters saturate at 32'hFFFF_FFFF.
//  - Reset mid-LDSTALL/DRAIN/HALT returns to RUN; no pending state survives.
// CONFIGURATION
//  HAZARD_STATS_EN defined: stall_cnt/flush_cnt are live 32-bit saturating counters.
//  Not defined: counter regs not built; stall_cnt/flush_cnt tied to 0; control identical.
// TESTING
//  1 lw $t0 in EX (ex_wreg=8), ID add rs=8 -> 1 cycle pc_en=0,if_id_en=0,id_ex_zero=1; stall_cnt=1.
//  2 LOAD_STALL_CYCLES=3, same hazard -> 3 consecutive bubble cycles, then RUN; stall_cnt=3.
//  3 ex_wreg=0 with id_rs=0, ex_ld=1 -> no stall, pc_en=1, id_ex_stall=1.
//  4 ex_redirect=1 with ldu=1 same cycle -> flush (if_id_zero=id_ex_zero=1, pc_en=1); flush_cnt=1, stall_cnt=0.
//  5 ex_syscall, ex_v0=10 -> 2 DRAIN cycles then halt=1; ex_v0=4 -> no halt; resume -> RUN next cycle.
//  6 rst_n low during DRAIN -> outputs to reset values immediately; release -> RUN, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : pipeline stall/flush/halt sequencer for the 5-stage MIPS core.
//               Define HAZARD_STATS_EN to build the stall/flush event counters.
// Rev 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES      = 2,
  parameter logic [31:0] HALT_CODE         = 32'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_use_rs,
  input  logic        i_id_use_rt,
  input  logic        i_ex_ld,
  input  logic [4:0]  i_ex_wreg,
  input  logic        i_ex_redirect,
  input  logic        i_ex_syscall,
  input  logic [31:0] i_ex_v0,
  input  logic        i_resume,
  output logic        o_pc_en,
  output logic        o_if_id_en,
  output logic        o_if_id_zero,
  output logic        o_id_ex_stall,
  output logic        o_id_ex_zero,
  output logic        o_halt,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LDSTALL = 2'd1,
    S_DRAIN   = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  // The detection cycle already supplies the first bubble, hence the -2.
  localparam logic [2:0] c_LDS_INIT   = (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
  localparam logic [2:0] c_DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
  localparam logic       c_MULTI_STALL = (LOAD_STALL_CYCLES > 1);

  state_t     r_state;
  logic [2:0] r_cnt;

  logic w_ldu;
  logic w_hlt;

  assign w_ldu = i_ex_ld && (i_ex_wreg != 5'd0) &&
                 ((i_id_use_rs && (i_id_rs == i_ex_wreg)) ||
                  (i_id_use_rt && (i_id_rt == i_ex_wreg)));
  assign w_hlt = i_ex_syscall && (i_ex_v0 == HALT_CODE);

  always_comb begin
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_zero  = 1'b0;
    o_id_ex_stall = 1'b0;
    o_id_ex_zero  = 1'b0;
    o_halt        = 1'b0;
    if (!rst_n) begin
      o_if_id_zero = 1'b1;
      o_id_ex_zero = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_hlt) begin
            o_id_ex_zero = 1'b1;
          end else if (i_ex_redirect) begin
            o_pc_en      = 1'b1;
            o_if_id_zero = 1'b1;
            o_id_ex_zero = 1'b1;
          end else if (w_ldu) begin
            o_id_ex_zero = 1'b1;
          end else begin
            o_pc_en       = 1'b1;
            o_if_id_en    = 1'b1;
            o_id_ex_stall = 1'b1;
          end
        end
        S_LDSTALL, S_DRAIN: o_id_ex_zero = 1'b1;
        S_HALT:             o_halt       = 1'b1;
        default:            o_id_ex_zero = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_hlt) begin
            r_state <= S_DRAIN;
            r_cnt   <= c_DRAIN_INIT;
          end else if (!i_ex_redirect && w_ldu && c_MULTI_STALL) begin
            r_state <= S_LDSTALL;
            r_cnt   <= c_LDS_INIT;
          end
        end
        S_LDSTALL: begin
          if (r_cnt == 3'd0) r_state <= S_RUN;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_DRAIN: begin
          if (r_cnt == 3'd0) r_state <= S_HALT;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_HALT: begin
          if (i_resume) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic        w_stall_evt;
  logic        w_flush_evt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  assign w_stall_evt = (r_state == S_LDSTALL) ||
                       ((r_state == S_RUN) && !w_hlt && !i_ex_redirect && w_ldu);
  assign w_flush_evt = (r_state == S_RUN) && !w_hlt && i_ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_evt && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : two hazard_ctrl instances (1-bubble/2-drain and
//                  3-bubble/4-drain) against a cycle-level reference model.
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_wreg;
  logic        id_use_rs, id_use_rt, ex_ld, ex_redirect, ex_syscall, resume;
  logic [31:0] ex_v0;

  logic        a_pc_en, a_if_id_en, a_if_id_zero, a_id_ex_stall, a_id_ex_zero, a_halt;
  logic        b_pc_en, b_if_id_en, b_if_id_zero, b_id_ex_stall, b_id_ex_zero, b_halt;
  logic [31:0] a_stall, a_flush, b_stall, b_flush;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .DRAIN_CYCLES(2), .HALT_CODE(32'd10)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_ex_ld(ex_ld), .i_ex_wreg(ex_wreg), .i_ex_redirect(ex_redirect),
    .i_ex_syscall(ex_syscall), .i_ex_v0(ex_v0), .i_resume(resume),
    .o_pc_en(a_pc_en), .o_if_id_en(a_if_id_en), .o_if_id_zero(a_if_id_zero),
    .o_id_ex_stall(a_id_ex_stall), .o_id_ex_zero(a_id_ex_zero), .o_halt(a_halt),
    .o_stall_cnt(a_stall), .o_flush_cnt(a_flush)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(4), .HALT_CODE(32'd10)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_ex_ld(ex_ld), .i_ex_wreg(ex_wreg), .i_ex_redirect(ex_redirect),
    .i_ex_syscall(ex_syscall), .i_ex_v0(ex_v0), .i_resume(resume),
    .o_pc_en(b_pc_en), .o_if_id_en(b_if_id_en), .o_if_id_zero(b_if_id_zero),
    .o_id_ex_stall(b_id_ex_stall), .o_id_ex_zero(b_id_ex_zero), .o_halt(b_halt),
    .o_stall_cnt(b_stall), .o_flush_cnt(b_flush)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: bubbles / drain cycles still owed, halted flag, event counts.
  int          ls_m[2] = '{1, 3};
  int          dr_m[2] = '{2, 4};
  int          bub[2];
  int          drn[2];
  bit          halted[2];
  logic [31:0] st_c[2];
  logic [31:0] fl_c[2];

  function automatic bit m_ldu();
    return ex_ld && (ex_wreg != 5'd0) &&
           ((id_use_rs && id_rs == ex_wreg) || (id_use_rt && id_rt == ex_wreg));
  endfunction

  function automatic bit m_hlt();
    return ex_syscall && (ex_v0 == 32'd10);
  endfunction

  // Bit order: {pc_en, if_id_en, if_id_zero, id_ex_stall, id_ex_zero, halt}
  function automatic logic [5:0] exp_ctl(int k);
    if (!rst_n)                 return 6'b001010;
    if (halted[k])              return 6'b000001;
    if (drn[k] > 0 || bub[k] > 0) return 6'b000010;
    if (m_hlt())                return 6'b000010;
    if (ex_redirect)            return 6'b101010;
    if (m_ldu())                return 6'b000010;
    return 6'b110100;
  endfunction

  function automatic logic [31:0] exp_cnt(logic [31:0] v);
`ifdef HAZARD_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  function automatic logic [139:0] expected();
    return {exp_ctl(0), exp_ctl(1),
            exp_cnt(st_c[0]), exp_cnt(fl_c[0]), exp_cnt(st_c[1]), exp_cnt(fl_c[1])};
  endfunction

  function automatic logic [139:0] observed();
    return {a_pc_en, a_if_id_en, a_if_id_zero, a_id_ex_stall, a_id_ex_zero, a_halt,
            b_pc_en, b_if_id_en, b_if_id_zero, b_id_ex_stall, b_id_ex_zero, b_halt,
            a_stall, a_flush, b_stall, b_flush};
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      bub[k] = 0; drn[k] = 0; halted[k] = 1'b0; st_c[k] = 32'd0; fl_c[k] = 32'd0;
    end
  endtask

  task automatic model_tick(int k);
    if (!rst_n) return;
    if (halted[k]) begin
      if (resume) halted[k] = 1'b0;
    end else if (drn[k] > 0) begin
      drn[k]--;
      if (drn[k] == 0) halted[k] = 1'b1;
    end else if (bub[k] > 0) begin
      bub[k]--;
      st_c[k] = sat_inc(st_c[k]);
    end else if (m_hlt()) begin
      drn[k] = dr_m[k];
    end else if (ex_redirect) begin
      fl_c[k] = sat_inc(fl_c[k]);
    end else if (m_ldu()) begin
      st_c[k] = sat_inc(st_c[k]);
      bub[k]  = ls_m[k] - 1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_tick(0);
    model_tick(1);
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_ld = 1'b0; ex_wreg = 5'd0; ex_redirect = 1'b0; ex_syscall = 1'b0;
    ex_v0 = 32'd0; resume = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    set_idle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    #1;
    compared++;
    if (observed() !== expected()) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want %h", observed(), expected());
    end
    compared++;
    if ({a_pc_en, a_if_id_en, a_id_ex_stall, a_if_id_zero, a_id_ex_zero, a_halt} !== 6'b000110) begin
      mismatched++;
      $display("FAIL reset_pins: got %b want 000110",
               {a_pc_en, a_if_id_en, a_id_ex_stall, a_if_id_zero, a_id_ex_zero, a_halt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (observed() !== expected()) begin
      mismatched++;
      $display("FAIL reset_release: got %h want %h", observed(), expected());
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_ld = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; id_rt = 5'd9; id_use_rt = 1'b1;
    #1;
    compared++;
    if (observed() !== expected()) begin
      mismatched++;
      $display("FAIL load_use_detect: got %h want %h", observed(), expected());
    end
    next_cycle();
    set_idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      compared++;
      if (observed() !== expected()) begin
        mismatched++;
        $display("FAIL load_use_after[%0d]: got %h want %h", i, observed(), expected());
      end
      next_cycle();
    end
`ifdef HAZARD_STATS_EN
    compared++;
    if (a_stall !== 32'd1 || b_stall !== 32'd3) begin
      mismatched++;
      $display("FAIL load_use_counts: got a=%0d b=%0d want a=1 b=3", a_stall, b_stall);
    end
`endif
  endtask

  task automatic test_zero_reg();
    ex_ld = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    compared++;
    if (observed() !== expected() || a_pc_en !== 1'b1 || a_id_ex_stall !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_reg_no_stall: got %h want %h", observed(), expected());
    end
    next_cycle();
    set_idle();
  endtask

  task automatic test_redirect_priority();
    do_reset();
    ex_ld = 1'b1; ex_wreg = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1; ex_redirect = 1'b1;
    #1;
    compared++;
    if (observed() !== expected() || {a_pc_en, a_if_id_zero, a_id_ex_zero} !== 3'b111) begin
      mismatched++;
      $display("FAIL redirect_over_ldu: got %h want %h", observed(), expected());
    end
    next_cycle();
    set_idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      compared++;
      if (observed() !== expected()) begin
        mismatched++;
        $display("FAIL redirect_after[%0d]: got %h want %h", i, observed(), expected());
      end
      next_cycle();
    end
`ifdef HAZARD_STATS_EN
    compared++;
    if (a_flush !== 32'd1 || a_stall !== 32'd0 || b_flush !== 32'd1 || b_stall !== 32'd0) begin
      mismatched++;
      $display("FAIL redirect_counts: got af=%0d as=%0d bf=%0d bs=%0d want 1 0 1 0",
               a_flush, a_stall, b_flush, b_stall);
    end
`endif
  endtask

  task automatic test_halt();
    set_idle();
    ex_syscall = 1'b1; ex_v0 = 32'd4;
    #1;
    compared++;
    if (observed() !== expected() || a_pc_en !== 1'b1) begin
      mismatched++;
      $display("FAIL syscall_non_halt: got %h want %h", observed(), expected());
    end
    next_cycle();
    ex_v0 = 32'd10;
    #1;
    compared++;
    if (observed() !== expected()) begin
      mismatched++;
      $display("FAIL syscall_halt_detect: got %h want %h", observed(), expected());
    end
    next_cycle();
    set_idle();
    for (int i = 0; i < 8; i++) begin
      #1;
      compared++;
      if (observed() !== expected()) begin
        mismatched++;
        $display("FAIL drain_halt[%0d]: got %h want %h", i, observed(), expected());
      end
      next_cycle();
    end
    compared++;
    if (a_halt !== 1'b1 || b_halt !== 1'b1) begin
      mismatched++;
      $display("FAIL halted_both: got a=%b b=%b want 1 1", a_halt, b_halt);
    end
    resume = 1'b1;
    #1;
    compared++;
    if (observed() !== expected()) begin
      mismatched++;
      $display("FAIL resume_cycle: got %h want %h", observed(), expected());
    end
    next_cycle();
    resume = 1'b0;
    #1;
    compared++;
    if (observed() !== expected() || a_halt !== 1'b0 || a_pc_en !== 1'b1) begin
      mismatched++;
      $display("FAIL after_resume: got %h want %h", observed(), expected());
    end
    next_cycle();
  endtask

  task automatic test_reset_in_drain();
    set_idle();
    ex_ld = 1'b1; ex_wreg = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
    #1;
    next_cycle();
    set_idle();
    ex_syscall = 1'b1; ex_v0 = 32'd10;
    #1;
    next_cycle();
    set_idle();
    #1;
    compared++;
    if (observed() !== expected()) begin
      mismatched++;
      $display("FAIL drain_entry: got %h want %h", observed(), expected());
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (observed() !== expected()) begin
      mismatched++;
      $display("FAIL reset_in_drain: got %h want %h", observed(), expected());
    end
    next_cycle();
    rst_n = 1'b1;
    #1;
    compared++;
    if (observed() !== expected() || a_pc_en !== 1'b1 || b_pc_en !== 1'b1) begin
      mismatched++;
      $display("FAIL release_from_drain: got %h want %h", observed(), expected());
    end
    next_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_wreg     = 5'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      ex_ld       = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 7) == 0);
      ex_syscall  = ($urandom_range(0, 15) == 0);
      ex_v0       = ($urandom_range(0, 1) == 0) ? 32'd10 : 32'($urandom_range(0, 12));
      resume      = ($urandom_range(0, 3) == 0);
      #1;
      compared++;
      if (observed() !== expected()) begin
        mismatched++;
        $display("FAIL random[%0d]: got %h want %h", i, observed(), expected());
      end
      next_cycle();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_redirect_priority();
    test_halt();
    test_reset_in_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
